// File: rtl/port_merge_arb.sv
// Four-port FIFO merge with round-robin arbitration onto one valid/ready stream.
// Define PORT_MERGE_STATS_EN to add the beat_count / drop_count statistics outputs.
module port_merge_arb #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] i0_data,
  input  logic [DATA_W-1:0] i1_data,
  input  logic [DATA_W-1:0] i2_data,
  input  logic [DATA_W-1:0] i3_data,
  input  logic              i0_valid,
  input  logic              i1_valid,
  input  logic              i2_valid,
  input  logic              i3_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        overflow,
  input  logic              clr_ovf
`ifdef PORT_MERGE_STATS_EN
  ,
  output logic [15:0]       beat_count,
  output logic [15:0]       drop_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] in_data [4];
  logic [3:0]        in_valid;

  logic [DATA_W-1:0] mem_q [4][DEPTH];
  logic [DATA_W-1:0] mem_d [4][DEPTH];
  logic [AW-1:0]     wptr_q [4];
  logic [AW-1:0]     wptr_d [4];
  logic [AW-1:0]     rptr_q [4];
  logic [AW-1:0]     rptr_d [4];
  logic [CW-1:0]     cnt_q [4];
  logic [CW-1:0]     cnt_d [4];

  logic [3:0]        nonempty, full, push, pop, drop;
  logic [1:0]        last_grant_q, last_grant_d;
  logic [1:0]        gnt_idx, cand;
  logic              gnt_found, load;

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_src_q, out_src_d;
  logic              out_valid_q, out_valid_d;
  logic [3:0]        overflow_q, overflow_d;

  always_comb begin
    in_data[0]  = i0_data;
    in_data[1]  = i1_data;
    in_data[2]  = i2_data;
    in_data[3]  = i3_data;
    in_valid    = {i3_valid, i2_valid, i1_valid, i0_valid};
  end

  always_comb begin
    nonempty = '0;
    full     = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      nonempty[k] = (cnt_q[k] != '0);
      full[k]     = (cnt_q[k] == CW'(DEPTH));
    end

    // Search starts one past the last grant; k == 4 wraps back to last_grant itself.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = 2'(last_grant_q + 2'(k));
      if (!gnt_found && nonempty[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end

    load         = !out_valid_q || out_ready;
    pop          = '0;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (load) begin
      if (gnt_found) begin
        pop[gnt_idx] = 1'b1;
        out_valid_d  = 1'b1;
        out_data_d   = mem_q[gnt_idx][rptr_q[gnt_idx]];
        out_src_d    = gnt_idx;
        last_grant_d = gnt_idx;
      end else begin
        out_valid_d  = 1'b0;
      end
    end

    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    push   = '0;
    drop   = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
      push[k] = in_valid[k] && (!full[k] || pop[k]);
      drop[k] = in_valid[k] && full[k] && !pop[k];
      if (push[k]) begin
        mem_d[k][wptr_q[k]] = in_data[k];
        wptr_d[k]           = wptr_q[k] + AW'(1);
      end
      if (pop[k]) begin
        rptr_d[k] = rptr_q[k] + AW'(1);
      end
      if (push[k] && !pop[k]) begin
        cnt_d[k] = cnt_q[k] + CW'(1);
      end else if (pop[k] && !push[k]) begin
        cnt_d[k] = cnt_q[k] - CW'(1);
      end
    end

    overflow_d = clr_ovf ? drop : (overflow_q | drop);
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < 4; k++) begin
        wptr_q[k] <= '0;
        rptr_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      last_grant_q <= 2'd3;
      out_data_q   <= '0;
      out_src_q    <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

`ifdef PORT_MERGE_STATS_EN
  logic [15:0] beat_count_q, beat_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic [2:0]  ndrops;
  logic [16:0] drop_sum;

  always_comb begin
    ndrops       = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    beat_count_d = clr_ovf ? '0 : beat_count_q + 16'(out_valid_q && out_ready);
    drop_sum     = {1'b0, (clr_ovf ? 16'h0000 : drop_count_q)} + 17'(ndrops);
    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      beat_count_q <= beat_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign beat_count = beat_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_port_merge_arb.sv
// Directed self-checking bench for port_merge_arb (DEPTH=4, DATA_W=8).
module tb_port_merge_arb;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] i0_data, i1_data, i2_data, i3_data;
  logic       i0_valid, i1_valid, i2_valid, i3_valid;
  logic [7:0] out_data;
  logic [1:0] out_src;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] overflow;
  logic       clr_ovf;
`ifdef PORT_MERGE_STATS_EN
  logic [15:0] beat_count, drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  port_merge_arb #(.DEPTH(4), .DATA_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i0_data   (i0_data),
    .i1_data   (i1_data),
    .i2_data   (i2_data),
    .i3_data   (i3_data),
    .i0_valid  (i0_valid),
    .i1_valid  (i1_valid),
    .i2_valid  (i2_valid),
    .i3_valid  (i3_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
`ifdef PORT_MERGE_STATS_EN
    ,
    .beat_count(beat_count),
    .drop_count(drop_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    if (v) begin
      chk({tag, "_src"}, 32'(out_src), 32'(s));
      chk({tag, "_data"}, 32'(out_data), 32'(d));
    end
  endtask

  task automatic idle_inputs();
    i0_valid = 1'b0;
    i1_valid = 1'b0;
    i2_valid = 1'b0;
    i3_valid = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  task automatic all_four();
    i0_valid = 1'b1; i0_data = 8'h10;
    i1_valid = 1'b1; i1_data = 8'h11;
    i2_valid = 1'b1; i2_data = 8'h12;
    i3_valid = 1'b1; i3_data = 8'h13;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b0;
    i0_data = '0; i1_data = '0; i2_data = '0; i3_data = '0;
    idle_inputs();
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_src", 32'(out_src), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;

    // Single beat on port 2: visible two cycles later, gone the cycle after.
    out_ready = 1'b1;
    i2_valid = 1'b1; i2_data = 8'hA5;
    step();
    idle_inputs();
    chk_out("single_c1", 1'b0, 2'd0, 8'h00);
    step();
    chk_out("single_c2", 1'b1, 2'd2, 8'hA5);
    step();
    chk_out("single_c3", 1'b0, 2'd0, 8'h00);

    // Four simultaneous beats from reset: port 0 first.
    do_reset();
    out_ready = 1'b1;
    all_four();
    step();
    idle_inputs();
    chk_out("rr0_c1", 1'b0, 2'd0, 8'h00);
    step(); chk_out("rr0_b0", 1'b1, 2'd0, 8'h10);
    step(); chk_out("rr0_b1", 1'b1, 2'd1, 8'h11);
    step(); chk_out("rr0_b2", 1'b1, 2'd2, 8'h12);
    step(); chk_out("rr0_b3", 1'b1, 2'd3, 8'h13);
    step(); chk_out("rr0_end", 1'b0, 2'd0, 8'h00);

    // Last grant to port 1, then four simultaneous beats: order 2,3,0,1.
    i1_valid = 1'b1; i1_data = 8'h21;
    step();
    idle_inputs();
    step();
    chk_out("rr1_pre", 1'b1, 2'd1, 8'h21);
    all_four();
    step();
    idle_inputs();
    chk_out("rr1_gap", 1'b0, 2'd0, 8'h00);
    step(); chk_out("rr1_b0", 1'b1, 2'd2, 8'h12);
    step(); chk_out("rr1_b1", 1'b1, 2'd3, 8'h13);
    step(); chk_out("rr1_b2", 1'b1, 2'd0, 8'h10);
    step(); chk_out("rr1_b3", 1'b1, 2'd1, 8'h11);
    step(); chk_out("rr1_end", 1'b0, 2'd0, 8'h00);

    // Backpressure: last_grant=1, ports 0 and 3 pending; port 3 wins and holds.
    out_ready = 1'b0;
    i0_valid = 1'b1; i0_data = 8'h30;
    i3_valid = 1'b1; i3_data = 8'h33;
    step();
    i3_valid = 1'b0;
    i0_data  = 8'h31;
    step();
    idle_inputs();
    chk_out("hold0", 1'b1, 2'd3, 8'h33);
    for (int h = 1; h < 5; h++) begin
      step();
      chk_out("hold", 1'b1, 2'd3, 8'h33);
    end
    out_ready = 1'b1;
    step(); chk_out("hold_d0", 1'b1, 2'd0, 8'h30);
    step(); chk_out("hold_d1", 1'b1, 2'd0, 8'h31);
    step(); chk_out("hold_end", 1'b0, 2'd0, 8'h00);

    // Overflow on port 1: 6 beats with out_ready=0, 0x05 is dropped.
    out_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      i1_valid = 1'b1;
      i1_data  = 8'(j);
      if (j == 5) chk("ovf_before_drop", 32'(overflow), 32'h0);
      step();
    end
    idle_inputs();
    chk("ovf_set", 32'(overflow), 32'h2);
    chk_out("ovf_d0", 1'b1, 2'd1, 8'h00);
    out_ready = 1'b1;
    for (int j = 1; j < 5; j++) begin
      step();
      chk_out("ovf_d", 1'b1, 2'd1, 8'(j));
    end
    step();
    chk_out("ovf_end", 1'b0, 2'd0, 8'h00);
    chk("ovf_sticky", 32'(overflow), 32'h2);

    // Clear: takes effect on the next edge.
    clr_ovf = 1'b1;
    chk("clr_pre", 32'(overflow), 32'h2);
    step();
    clr_ovf = 1'b0;
    chk("clr_post", 32'(overflow), 32'h0);

    // Fill FIFO 0 (reg + 4 entries), then push while draining: no drop.
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      i0_valid = 1'b1;
      i0_data  = 8'(8'h40 + j);
      step();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      chk_out("full_pp", 1'b1, 2'd0, 8'(8'h40 + j));
      if (j < 5) begin
        i0_valid = 1'b1;
        i0_data  = 8'(8'h45 + j);
      end else begin
        i0_valid = 1'b0;
      end
      step();
    end
    chk_out("full_pp_end", 1'b0, 2'd0, 8'h00);
    chk("full_pp_ovf", 32'(overflow), 32'h0);

    // Async reset mid-stream: last_grant=0, so port 1 is presented first.
    out_ready = 1'b0;
    i0_valid = 1'b1; i0_data = 8'h50;
    i1_valid = 1'b1; i1_data = 8'h51;
    step();
    idle_inputs();
    step();
    chk_out("arst_pre", 1'b1, 2'd1, 8'h51);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_src", 32'(out_src), 32'd0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      step();
      chk_out("arst_empty", 1'b0, 2'd0, 8'h00);
    end

    // Drop coinciding with clr_ovf: the drop wins, then a lone clear empties it.
    out_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      i2_valid = 1'b1;
      i2_data  = 8'(8'h60 + j);
      if (j == 5) clr_ovf = 1'b1;
      step();
    end
    idle_inputs();
    chk("clr_drop_wins", 32'(overflow), 32'h4);
    chk_out("clr_drop_out", 1'b1, 2'd2, 8'h60);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_after", 32'(overflow), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/port_merge_arb.md
# port_merge_arb

Downstream merge stage for the 4-way source demux. Captures the four per-destination byte streams (`oN_data` / `oN_valid`), buffers each in its own small FIFO, and serialises them onto one output stream. The output stream uses a valid/ready handshake and is arbitrated round-robin. The demux has no backpressure, so a full FIFO drops the incoming beat and sets a sticky per-port overflow flag.

## Interface

**Parameters**
- `DEPTH`, default 4: entries per port FIFO. Power of two, minimum 2.
- `DATA_W`, default 8: data width per beat.

**Ports**
- `clk` input, 1: the single clock. All logic is rising-edge.
- `reset_n` input, 1: asynchronous, active-low reset. Assertion takes effect immediately; deassertion is sampled on `clk`.
- `i0_data` .. `i3_data` input, DATA_W each: per-port data from the demux.
- `i0_valid` .. `i3_valid` input, 1 each: per-port beat strobe. No ready is returned.
- `out_data` output, DATA_W: merged data.
- `out_src` output, 2: index of the port that produced `out_data`.
- `out_valid` output, 1: output beat present.
- `out_ready` input, 1: downstream accepts the beat.
- `overflow` output, 4: sticky drop flag, one bit per port.
- `clr_ovf` input, 1: synchronous clear of all `overflow` bits.

## Operation

**Write side**
- On each rising edge where `iK_valid` = 1, `iK_data` is pushed into FIFO K.
- If FIFO K is full and is not popped in that cycle, the beat is dropped and `overflow[K]` is set.
- If FIFO K is full and is popped in the same cycle, the push is accepted and no overflow occurs.

**Per-FIFO state**
- Write pointer, read pointer, and a count of width log2(DEPTH)+1.
- Pointers wrap modulo DEPTH.

**Output register**
- `out_data`, `out_src` and `out_valid` are registered.
- The register loads when it is empty (`out_valid` = 0) or draining (`out_valid` & `out_ready`).

**Arbiter**
- Round-robin over the non-empty FIFOs.
- Search order starts at `(last_grant + 1) mod 4`.
- On a load, the granted FIFO pops and `last_grant` updates to the granted port.
- If every FIFO is empty and the register is draining, `out_valid` goes to 0.

**Output stability**
- While `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_src` hold stable.

**Overflow clear**
- `clr_ovf` clears all `overflow` bits on the next edge.
- A drop in the same cycle as `clr_ovf` wins: that bit stays set.

**Reset values**
- `out_valid` = 0, `out_data` = 0, `out_src` = 0, `overflow` = 0.
- FIFOs empty, `last_grant` = 3, so port 0 has first priority.
- Reset asserted mid-operation discards all buffered beats immediately.

## Timing

- Latency from `iK_valid` high in cycle N to `out_valid` high is 2 cycles (cycle N+2), provided the output register is free.
- Sustained throughput is 1 beat/cycle when `out_ready` = 1.
- The arbiter decision uses FIFO occupancy as of the start of the cycle. A beat pushed in cycle N is not eligible before cycle N+1.
- The input side allows up to 4 pushes/cycle, but the drain rate is 1 beat/cycle. Aggregate input above 1 beat/cycle overflows after DEPTH excess beats per port.
- There is no combinational path from `out_ready` to any output.

## Configuration

- `PORT_MERGE_STATS_EN` defined:
  - adds output `beat_count` (16-bit), which increments on each `out_valid` & `out_ready` and wraps from 0xFFFF to 0;
  - adds output `drop_count` (16-bit), which increments once per dropped beat and saturates at 0xFFFF;
  - both counters reset to 0 on reset and clear on `clr_ovf`.
- Macro undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan

- Single beat, `out_ready` = 1:
  - stimulus: `i2_valid` = 1, `i2_data` = 0xA5 for one cycle at cycle 0;
  - required: at cycle 2, `out_valid` = 1, `out_data` = 0xA5, `out_src` = 2; in the following cycle `out_valid` = 0.
- Simultaneous inputs, round-robin order:
  - stimulus: all four ports valid in one cycle with data 0x10, 0x11, 0x12, 0x13;
  - required: output sequence (src/data) 0/0x10, 1/0x11, 2/0x12, 3/0x13 on four consecutive cycles.
  - Repeat the same stimulus after a final grant to port 1; the order must then start at port 2.
- Backpressure hold:
  - stimulus: `out_ready` = 0 for 5 cycles while a beat is presented;
  - required: `out_data` and `out_src` stay constant and no beat is lost; after `out_ready` rises, beats drain in order.
- Overflow, with `DEPTH` = 4 and `out_ready` = 0:
  - stimulus: 6 consecutive beats 0x00..0x05 on port 1;
  - required: `overflow[1]` = 1; on release, the output yields 0x00–0x04. That is 5 beats: 1 held in the output register plus 4 in the FIFO. 0x05 is dropped.
- Full FIFO with simultaneous push and pop:
  - stimulus: FIFO 0 full and `out_ready` = 1 while pushing continuously;
  - required: no drop and `overflow[0]` stays 0.
- Asynchronous reset mid-stream, then clear:
  - stimulus: `reset_n` pulled low mid-burst;
  - required: `out_valid` drops to 0 without waiting for a clock edge and all FIFOs are empty.
  - Then pulse `clr_ovf` after an overflow: `overflow` returns to 0 on the next edge.
